// File: rtl/hex_uart_rx.sv
// hex_uart_rx: 8N1 UART receiver that assembles ASCII hex text into a
// right-justified DIGIT*4-bit word.
//
// Ports:
//   CLK    in             system clock
//   RST_X  in             asynchronous active-low reset
//   RXD    in             serial input, idle high, asynchronous to CLK
//   DATA   out [DIGIT*4]  last completed value, held until the next VALID
//   VALID  out            one-cycle pulse, DATA updated on the same edge
//   ERR    out            one-cycle pulse on framing error or illegal character
//
// Bit FSM states:
//   state   | meaning
//   S_IDLE  | line idle, waiting for rx low
//   S_START | counting to mid start bit, re-checking for a glitch
//   S_DATA  | sampling 8 data bits, one per WCNT clocks, LSB first
//   S_STOP  | waiting one bit period, then sampling the stop bit
module hex_uart_rx #(
  parameter int DIGIT = 8,
  parameter int WCNT  = 16
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic               RXD,
  output logic [DIGIT*4-1:0] DATA,
  output logic               VALID,
  output logic               ERR
);

  localparam int              NDW      = $clog2(DIGIT + 1);
  localparam logic [11:0]     HALF_CNT = 12'(WCNT / 2);
  localparam logic [11:0]     LAST_CNT = 12'(WCNT - 1);
  localparam logic [NDW-1:0]  DIG_MAX  = NDW'(DIGIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic         rx_meta;
  logic         rx;
  state_t       state_q, state_d;
  logic [11:0]  cnt_q, cnt_d;
  logic [2:0]   bit_q, bit_d;
  logic [7:0]   shift_q, shift_d;
  logic         byte_good_q, byte_good_d;
  logic         frm_err_q, frm_err_d;

  logic [DIGIT*4-1:0] acc_q;
  logic [NDW-1:0]     ndig_q;

  logic         is_hex;
  logic         is_term;
  logic [3:0]   nibble;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rx      <= rx_meta;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_good_q <= 1'b0;
      frm_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      byte_good_q <= byte_good_d;
      frm_err_q   <= frm_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_good_d = 1'b0;
    frm_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_CNT) begin
          if (rx) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_STOP: begin
        // Returning to IDLE at mid-stop lets a start bit that follows
        // immediately be caught without an idle gap.
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx) begin
            byte_good_d = 1'b1;
          end else begin
            frm_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // shift_q stays stable for well over a bit period after the stop sample,
  // so the decode stage can read it directly.
  always_comb begin
    is_hex  = 1'b0;
    is_term = 1'b0;
    nibble  = 4'd0;
    if (shift_q >= 8'h30 && shift_q <= 8'h39) begin
      is_hex = 1'b1;
      nibble = shift_q[3:0];
    end else if ((shift_q >= 8'h61 && shift_q <= 8'h66) ||
                 (shift_q >= 8'h41 && shift_q <= 8'h46)) begin
      is_hex = 1'b1;
      nibble = shift_q[3:0] + 4'd9;
    end else if (shift_q == 8'h20 || shift_q == 8'h0D || shift_q == 8'h0A) begin
      is_term = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      DATA   <= '0;
      VALID  <= 1'b0;
      ERR    <= 1'b0;
      acc_q  <= '0;
      ndig_q <= '0;
    end else begin
      VALID <= 1'b0;
      ERR   <= 1'b0;
      if (frm_err_q) begin
        ERR    <= 1'b1;
        acc_q  <= '0;
        ndig_q <= '0;
      end else if (byte_good_q) begin
        if (is_hex) begin
          acc_q <= {acc_q[DIGIT*4-5:0], nibble};
          if (ndig_q != DIG_MAX) begin
            ndig_q <= ndig_q + 1'b1;
          end
        end else if (is_term) begin
          // An empty terminator is dropped so CR LF yields a single result.
          if (ndig_q != '0) begin
            DATA   <= acc_q;
            VALID  <= 1'b1;
            acc_q  <= '0;
            ndig_q <= '0;
          end
        end else begin
          ERR    <= 1'b1;
          acc_q  <= '0;
          ndig_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_uart_rx.sv
module tb_hex_uart_rx;

  localparam int DIGIT = 8;
  localparam int WCNT  = 16;

  logic        CLK;
  logic        RST_X;
  logic        RXD;
  logic [31:0] DATA;
  logic        VALID;
  logic        ERR;

  hex_uart_rx #(.DIGIT(DIGIT), .WCNT(WCNT)) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .RXD   (RXD),
    .DATA  (DATA),
    .VALID (VALID),
    .ERR   (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: value of the digits typed so far (wraps mod 2^32,
  // which keeps the last eight digits) and how many digits are pending.
  logic [31:0] m_acc  = 0;
  int          m_ndig = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit char_is_hex(input byte b);
    return (b >= "0" && b <= "9") || (b >= "a" && b <= "f") || (b >= "A" && b <= "F");
  endfunction

  function automatic bit char_is_term(input byte b);
    return b == 8'h20 || b == 8'h0D || b == 8'h0A;
  endfunction

  function automatic int hex_val(input byte b);
    if (b >= "0" && b <= "9") return int'(b) - int'("0");
    if (b >= "a" && b <= "f") return int'(b) - int'("a") + 10;
    return int'(b) - int'("A") + 10;
  endfunction

  task automatic model_byte(input byte b, input bit frame_ok);
    ev_t e;
    if (!frame_ok) begin
      e.is_err = 1'b1; e.data = 0; exp_q.push_back(e);
      m_acc = 0; m_ndig = 0;
    end else if (char_is_hex(b)) begin
      m_acc  = m_acc * 16 + 32'(hex_val(b));
      m_ndig = m_ndig + 1;
    end else if (char_is_term(b)) begin
      if (m_ndig > 0) begin
        e.is_err = 1'b0; e.data = m_acc; exp_q.push_back(e);
      end
      m_acc = 0; m_ndig = 0;
    end else begin
      e.is_err = 1'b1; e.data = 0; exp_q.push_back(e);
      m_acc = 0; m_ndig = 0;
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One 8N1 frame. A bad stop bit is held low only past the stop sample
  // point, then the line idles so the tail is rejected as a start glitch.
  task automatic send_byte(input byte b, input bit frame_ok);
    logic [7:0] v;
    v = b;
    model_byte(b, frame_ok);
    RXD = 1'b0;
    wait_clks(WCNT);
    for (int i = 0; i < 8; i++) begin
      RXD = v[i];
      wait_clks(WCNT);
    end
    if (frame_ok) begin
      RXD = 1'b1;
      wait_clks(WCNT);
    end else begin
      RXD = 1'b0;
      wait_clks(WCNT / 2 + 4);
      RXD = 1'b1;
      wait_clks(2 * WCNT);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20 * WCNT) begin
      @(negedge CLK);
      budget++;
    end
    wait_clks(2 * WCNT);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes VALID or ERR.
  logic [31:0] last_data = 0;
  logic        prev_v = 1'b0;
  logic        prev_e = 1'b0;
  ev_t         mon_e;

  initial begin
    forever begin
      @(negedge CLK);
      if (!RST_X) begin
        last_data = 0;
      end else begin
        if (VALID || ERR) begin
          check("valid_err_exclusive", 32'(VALID & ERR), 32'd0);
          check("pulse_one_cycle", 32'(prev_v | prev_e), 32'd0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: VALID=%0b ERR=%0b DATA=%h, expected no event at %0t",
                     VALID, ERR, DATA, $time);
          end else begin
            mon_e = exp_q.pop_front();
            check("event_is_err", 32'(ERR), 32'(mon_e.is_err));
            if (mon_e.is_err) begin
              check("data_held_on_err", DATA, last_data);
            end else begin
              check("data_on_valid", DATA, mon_e.data);
              last_data = mon_e.data;
            end
          end
        end
      end
      prev_v = VALID;
      prev_e = ERR;
    end
  end

  initial begin
    byte c;
    int  r;
    RXD   = 1'b1;
    RST_X = 1'b0;
    #1;
    check("reset_data", DATA, 32'd0);
    check("reset_valid", 32'(VALID), 32'd0);
    check("reset_err", 32'(ERR), 32'd0);
    wait_clks(5);
    RST_X = 1'b1;
    wait_clks(3 * WCNT);

    send_str("1234abcd ");
    drain("drain_basic");
    send_str("FF\r\n");
    drain("drain_crlf");
    send_str("123456789a ");
    drain("drain_overflow");
    send_str("12g3 ");
    drain("drain_illegal");
    send_byte("5", 1'b0);
    send_str("7 ");
    drain("drain_framing");

    // Start-bit glitch: must produce nothing, and the next frame must decode.
    RXD = 1'b0;
    wait_clks(4);
    RXD = 1'b1;
    wait_clks(3 * WCNT);
    send_str("C0 ");
    drain("drain_glitch");

    // Reset in the middle of data bit 3.
    RXD = 1'b0;
    wait_clks(WCNT);
    RXD = 1'b1; wait_clks(WCNT);
    RXD = 1'b0; wait_clks(WCNT);
    RXD = 1'b1; wait_clks(WCNT);
    RXD = 1'b0; wait_clks(WCNT / 2);
    RST_X = 1'b0;
    #1;
    check("midframe_reset_data", DATA, 32'd0);
    check("midframe_reset_valid", 32'(VALID), 32'd0);
    check("midframe_reset_err", 32'(ERR), 32'd0);
    m_acc = 0;
    m_ndig = 0;
    RXD = 1'b1;
    wait_clks(4);
    RST_X = 1'b1;
    wait_clks(2 * WCNT);
    check("no_event_after_reset", 32'(exp_q.size()), 32'd0);
    send_str("a\n");
    drain("drain_after_reset");

    // Random text: hex of either case, terminators, illegal bytes, bad stops.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 19);
      if (r < 16) begin
        if (r < 10) c = byte'(int'("0") + r);
        else if ($urandom_range(0, 1) == 1) c = byte'(int'("a") + r - 10);
        else c = byte'(int'("A") + r - 10);
        send_byte(c, 1'b1);
      end else if (r < 18) begin
        r = $urandom_range(0, 2);
        c = (r == 0) ? 8'h20 : (r == 1) ? 8'h0D : 8'h0A;
        send_byte(c, 1'b1);
      end else if (r == 18) begin
        do c = byte'($urandom_range(0, 255));
        while (char_is_hex(c) || char_is_term(c));
        send_byte(c, 1'b1);
      end else begin
        send_byte(byte'($urandom_range(0, 255)), 1'b0);
      end
      if ($urandom_range(0, 3) == 0) wait_clks($urandom_range(1, 20));
    end
    send_byte(8'h20, 1'b1);
    drain("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_uart_rx.md
# hex_uart_rx

Serial receiver that turns a line of ASCII hexadecimal text on a UART pin into a DIGIT×4-bit binary word. It is the host-to-board input path for the board's debug/LCD serial link: the host types hex digits followed by a terminator, and the block presents the assembled value with a one-cycle valid strobe. Framing is 8N1, LSB first, with the bit period set by the codebase's `SERIAL_WCNT` (define.v).

## Interface
- `DIGIT`, 8: maximum hex digits held; `DATA` width is DIGIT×4.
- `WCNT`, `SERIAL_WCNT`: clocks per bit. Legal range 4..4095.
- `CLK` in 1: system clock.
- `RST_X` in 1: reset; one clock; reset is asynchronous and active-low.
- `RXD` in 1: serial input, idle high, asynchronous to `CLK`.
- `DATA` out DIGIT×4: last completed value, right-justified, zero-extended.
- `VALID` out 1: one-cycle pulse; `DATA` updated on the same edge.
- `ERR` out 1: one-cycle pulse on framing error or illegal character.

## Operation
- `RXD` passes through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value `rx`.
- Bit FSM, 12-bit wait counter, 3-bit bit index:
  - IDLE: wait for `rx`=0 → START, counter cleared.
  - START: at counter = WCNT/2 (integer division), sample; `rx`=1 → IDLE (glitch, no error); `rx`=0 → DATA, counter cleared.
  - DATA: every WCNT clocks, sample `rx` into the shift register (LSB first); after the 8th sample → STOP.
  - STOP: after WCNT clocks, sample. `rx`=1 → byte good; `rx`=0 → framing error. In both cases → IDLE on the same edge.
- Character decode, one registered stage after a good stop sample:
  - '0'–'9' (0x30–0x39), 'a'–'f' (0x61–0x66), 'A'–'F' (0x41–0x46): `acc <= {acc[DIGIT*4-5:0], nibble}`; `ndig` increments and saturates at DIGIT. When more than DIGIT digits arrive, the oldest digit falls off the top.
  - Terminator (0x20 space, 0x0D CR, 0x0A LF) with `ndig`>0: `DATA <= acc`, pulse `VALID`, clear `acc` and `ndig`.
  - Terminator with `ndig`=0: ignored, so CR LF produces one result.
  - Any other byte: pulse `ERR`, clear `acc` and `ndig`; `DATA` unchanged.
- Framing error: pulse `ERR`, clear `acc` and `ndig`, discard the byte.
- `DATA` holds until the next `VALID`.

## Timing
- Reset values (asynchronous): `DATA`=0, `VALID`=0, `ERR`=0, FSM=IDLE, `acc`=0, `ndig`=0, counters 0, synchronizer flops=1.
- Input latency: 2 clocks from `RXD` to `rx`.
- Data bit k (0..7) is sampled WCNT/2 + (k+1)·WCNT clocks after the first low `rx` cycle. The stop bit is sampled WCNT later.
- `VALID`/`ERR` rise one clock after the stop-sample edge and last exactly one cycle.
- The FSM is in IDLE at mid-stop, so a start bit that immediately follows a stop bit is caught. Back-to-back frames need no idle gap.
- `VALID` and `ERR` are never asserted in the same cycle.
- Reset asserted mid-frame aborts the frame with no partial output. The first falling edge after reset release starts a new frame.

## Test plan
- WCNT=16, DIGIT=8: send "1234abcd " back-to-back → exactly one `VALID`, `DATA`=0x1234abcd, `ERR` never high.
- "FF\r\n" → one `VALID`, `DATA`=0x000000FF. The LF produces no second pulse.
- "123456789a " (10 digits) → `DATA`=0x3456789a.
- "12g3 " → one `ERR` pulse at the 'g' decode, then `VALID` with `DATA`=0x00000003.
- '5' sent with stop bit 0 → `ERR` pulse, no `VALID`. Then "7 " → `DATA`=0x00000007.
- `RXD` low for 4 clocks then high → no `ERR`, no `VALID`, FSM back in IDLE. Assert `RST_X` during bit 3 of a frame → all outputs 0 immediately. A following "a\n" → `DATA`=0x0000000a.
